// File: rtl/seq_shifter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_shifter_pkg
// Description : Shared definitions for the iterative shifter. Holds the shift
//               op encodings and the control FSM state type.
//               Op 11 is a rotate only when SEQ_SHIFTER_ROTATE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_shifter_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : seq_shifter_pkg
`default_nettype wire

// File: rtl/seq_shifter_shift_stage.sv
`default_nettype none
// ============================================================================
// Module      : shift_stage
// Description : One barrel stage of the iterative shifter. It shifts by
//               2^stage when enabled and passes the data through otherwise.
//               Macro SEQ_SHIFTER_ROTATE_EN adds the rotate-left datapath;
//               without it op 11 decodes as SLL.
// Ports       : data_in     - working operand
//               op          - shift mode (SLL/SRL/SRA/ROL)
//               stage       - stage index k (shift distance 2^k)
//               enable      - amount bit k; 0 passes data through
//               sign        - original operand sign bit, used as SRA fill
//               data_out    - stage result
//               shifted_out - last bit shifted out (0 when not enabled)
// Revision    : 1.0 - initial release
// ============================================================================
module shift_stage
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]   data_in,
    input  logic [1:0]         op,
    input  logic [SHAMT_W-1:0] stage,
    input  logic               enable,
    input  logic               sign,
    output logic [WIDTH-1:0]   data_out,
    output logic               shifted_out
);

    // Stage distance is at most WIDTH/2, which always fits in SHAMT_W bits.
    logic [SHAMT_W-1:0] w_dist;
    logic [SHAMT_W-1:0] w_dist_m1;
    logic [WIDTH-1:0]   w_left;
    logic [WIDTH-1:0]   w_right;
    logic [WIDTH-1:0]   w_fill;
    // Shifting by one less than the distance puts the last bit shifted out
    // at the edge of the word, avoiding a variable bit select.
    logic [WIDTH-1:0]   w_left_pre;
    logic [WIDTH-1:0]   w_right_pre;

    assign w_dist      = SHAMT_W'(1) << stage;
    assign w_dist_m1   = w_dist - SHAMT_W'(1);
    assign w_left      = data_in << w_dist;
    assign w_right     = data_in >> w_dist;
    assign w_fill      = ~({WIDTH{1'b1}} >> w_dist);
    assign w_left_pre  = data_in << w_dist_m1;
    assign w_right_pre = data_in >> w_dist_m1;

`ifdef SEQ_SHIFTER_ROTATE_EN
    logic [2*WIDTH-1:0] w_dbl;
    logic [WIDTH-1:0]   w_rol;

    // Upper half of the doubled word shifted left is the rotated word.
    assign w_dbl = {data_in, data_in} << w_dist;
    assign w_rol = w_dbl[2*WIDTH-1:WIDTH];
`endif

    always_comb begin
        data_out    = data_in;
        shifted_out = 1'b0;
        if (enable) begin
            case (op)
                OP_SRL: begin
                    data_out    = w_right;
                    shifted_out = w_right_pre[0];
                end
                OP_SRA: begin
                    data_out    = w_right | (sign ? w_fill : '0);
                    shifted_out = w_right_pre[0];
                end
`ifdef SEQ_SHIFTER_ROTATE_EN
                OP_ROL: begin
                    // Bit leaving the top lands in bit 0, so carry equals
                    // the new LSB.
                    data_out    = w_rol;
                    shifted_out = w_left_pre[WIDTH-1];
                end
`endif
                default: begin
                    data_out    = w_left;
                    shifted_out = w_left_pre[WIDTH-1];
                end
            endcase
        end
    end

endmodule : shift_stage
`default_nettype wire

// File: rtl/seq_shifter.sv
`default_nettype none
// ============================================================================
// Module      : seq_shifter
// Description : Iterative log-stage shifter. Applies one barrel stage
//               (shift by 2^k) per clock, LSB of the amount first. The unit
//               spends exactly SHAMT_W cycles in SHIFT, independent of the
//               amount. Valid/ready on both sides; the result is held until
//               it is consumed. Optional macro SEQ_SHIFTER_ROTATE_EN enables
//               ROL on op 11; otherwise op 11 behaves as SLL.
// Ports       : clk, rst_n (async, active low)
//               in_valid/in_ready, in_data, in_amt, in_op - request side
//               out_valid/out_ready, out_data, out_carry, out_zero - result
// Revision    : 1.0 - initial release
// ============================================================================
module seq_shifter
    import seq_shifter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [$clog2(WIDTH)-1:0] in_amt,
    input  logic [1:0]               in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_carry,
    output logic                     out_zero
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam logic [SHAMT_W-1:0] c_last_k = SHAMT_W'(SHAMT_W - 1);

    state_t             r_state;
    state_t             w_next;

    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_amt;
    logic [1:0]         r_op;
    logic               r_sign;
    logic               r_carry;
    logic [SHAMT_W-1:0] r_k;

    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_carry;
    logic               r_out_zero;

    logic [SHAMT_W-1:0] w_amt_sh;
    logic               w_en;
    logic               w_last;
    logic [WIDTH-1:0]   w_stage_data;
    logic               w_stage_out;

    assign w_amt_sh = r_amt >> r_k;
    assign w_en     = w_amt_sh[0];
    assign w_last   = (r_k == c_last_k);

    shift_stage #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_stage (
        .data_in     (r_work),
        .op          (r_op),
        .stage       (r_k),
        .enable      (w_en),
        .sign        (r_sign),
        .data_out    (w_stage_data),
        .shifted_out (w_stage_out)
    );

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next = SHIFT;
            SHIFT:   if (w_last)    w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work      <= '0;
            r_amt       <= '0;
            r_op        <= OP_SLL;
            r_sign      <= 1'b0;
            r_carry     <= 1'b0;
            r_k         <= '0;
            r_out_data  <= '0;
            r_out_carry <= 1'b0;
            r_out_zero  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_work  <= in_data;
                        r_amt   <= in_amt;
                        r_op    <= in_op;
                        r_sign  <= in_data[WIDTH-1];
                        r_carry <= 1'b0;
                        r_k     <= '0;
                    end
                end
                SHIFT: begin
                    r_work <= w_stage_data;
                    r_k    <= r_k + SHAMT_W'(1);
                    if (w_en) begin
                        r_carry <= w_stage_out;
                    end
                    // Result registers only change when the final stage
                    // lands, so no partial result is ever visible.
                    if (w_last) begin
                        r_out_data  <= w_stage_data;
                        r_out_carry <= w_en ? w_stage_out : r_carry;
                        r_out_zero  <= (w_stage_data == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign out_carry = r_out_carry;
    assign out_zero  = r_out_zero;

endmodule : seq_shifter
`default_nettype wire

// File: tb/tb_seq_shifter.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_shifter
// Description : Self-checking bench for seq_shifter (WIDTH=16). Directed
//               vectors, randomized ops against a behavioural model,
//               backpressure and mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_shifter;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] in_data   = '0;
    logic [3:0]  in_amt    = '0;
    logic [1:0]  in_op     = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_carry;
    logic        out_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_shifter #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_zero  (out_zero)
    );

    // Behavioural reference: whole-word shift by the full amount.
    // Returns {carry, result}.
    function automatic logic [16:0] model(input logic [15:0] d, input int a,
                                          input logic [1:0] op);
        logic [15:0] r;
        logic [15:0] t;
        logic        c;
        logic [1:0]  eop;
        eop = op;
`ifndef SEQ_SHIFTER_ROTATE_EN
        if (eop == 2'b11) eop = 2'b00;
`endif
        c = 1'b0;
        case (eop)
            2'b00: begin
                r = d << a;
                t = d >> (16 - a);
                if (a != 0) c = t[0];
            end
            2'b01: begin
                r = d >> a;
                t = d >> (a - 1);
                if (a != 0) c = t[0];
            end
            2'b10: begin
                r = $signed(d) >>> a;
                t = d >> (a - 1);
                if (a != 0) c = t[0];
            end
            default: begin
                r = (a == 0) ? d : ((d << a) | (d >> (16 - a)));
                if (a != 0) c = r[0];
            end
        endcase
        return {c, r};
    endfunction

    // Issue one request from IDLE, wait for the result, consume it.
    // lat = edges after acceptance until out_valid; 20 means timed out.
    task automatic run_op(input logic [15:0] d, input logic [3:0] a,
                          input logic [1:0] op, output logic [15:0] rd,
                          output logic rc, output logic rz, output int lat);
        @(negedge clk);
        in_data   = d;
        in_amt    = a;
        in_op     = op;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        rd = out_data;
        rc = out_carry;
        rz = out_zero;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got %h want 0000", out_data); end
        checks++; if (out_carry !== 1'b0) begin errors++; $display("FAIL reset_out_carry got %b want 0", out_carry); end
        checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL reset_out_zero got %b want 0", out_zero); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [15:0] d;
        logic [3:0]  a;
        logic [1:0]  op;
        logic [15:0] ed;
        logic        ec;
        logic        ez;
    } vec_t;

    task automatic test_directed();
        vec_t        v[6];
        logic [15:0] rd;
        logic        rc, rz;
        int          lat;
        v[0] = '{16'h4C01, 4'd1,  2'b00, 16'h9802, 1'b0, 1'b0};
        v[1] = '{16'h8000, 4'd15, 2'b10, 16'hFFFF, 1'b0, 1'b0};
        v[2] = '{16'h800F, 4'd4,  2'b01, 16'h0800, 1'b1, 1'b0};
        v[3] = '{16'h1234, 4'd0,  2'b00, 16'h1234, 1'b0, 1'b0};
        v[4] = '{16'h0000, 4'd0,  2'b00, 16'h0000, 1'b0, 1'b1};
`ifdef SEQ_SHIFTER_ROTATE_EN
        v[5] = '{16'h8001, 4'd4,  2'b11, 16'h0018, 1'b0, 1'b0};
`else
        v[5] = '{16'h8001, 4'd4,  2'b11, 16'h0010, 1'b0, 1'b0};
`endif
        for (int i = 0; i < 6; i++) begin
            run_op(v[i].d, v[i].a, v[i].op, rd, rc, rz, lat);
            checks++; if (lat !== 4) begin errors++; $display("FAIL dir%0d_latency got %0d want 4", i, lat); end
            checks++; if (rd !== v[i].ed) begin errors++; $display("FAIL dir%0d_data got %h want %h", i, rd, v[i].ed); end
            checks++; if (rc !== v[i].ec) begin errors++; $display("FAIL dir%0d_carry got %b want %b", i, rc, v[i].ec); end
            checks++; if (rz !== v[i].ez) begin errors++; $display("FAIL dir%0d_zero got %b want %b", i, rz, v[i].ez); end
        end
    endtask

    task automatic test_random();
        logic [15:0] d, rd;
        logic [3:0]  a;
        logic [1:0]  op;
        logic        rc, rz;
        logic [16:0] exp;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            d  = 16'($urandom);
            a  = 4'($urandom_range(0, 15));
            op = 2'($urandom_range(0, 3));
            if (i % 8 == 0) d = 16'h8000 | d;
            if (i % 10 == 0) a = 4'd15;
            exp = model(d, int'(a), op);
            run_op(d, a, op, rd, rc, rz, lat);
            checks++; if (lat !== 4) begin errors++; $display("FAIL rnd%0d_latency got %0d want 4", i, lat); end
            checks++; if (rd !== exp[15:0]) begin errors++; $display("FAIL rnd%0d_data op=%0d d=%h a=%0d got %h want %h", i, op, d, a, rd, exp[15:0]); end
            checks++; if (rc !== exp[16]) begin errors++; $display("FAIL rnd%0d_carry op=%0d d=%h a=%0d got %b want %b", i, op, d, a, rc, exp[16]); end
            checks++; if (rz !== (exp[15:0] == 16'h0)) begin errors++; $display("FAIL rnd%0d_zero got %b want %b", i, rz, (exp[15:0] == 16'h0)); end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        in_data  = 16'h00F0;
        in_amt   = 4'd2;
        in_op    = 2'b01;
        in_valid = 1'b1;
        @(posedge clk);
        // Second request is presented while the first one is still busy.
        #1 in_data = 16'hABCD; in_amt = 4'd3; in_op = 2'b00;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            if (out_valid) break;
            lat++;
        end
        checks++; if (lat >= 20) begin errors++; $display("FAIL bp_timeout got %0d cycles want <20", lat); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold%0d_valid got %b want 1", i, out_valid); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d_in_ready got %b want 0", i, in_ready); end
            checks++; if (out_data !== 16'h003C) begin errors++; $display("FAIL bp_hold%0d_data got %h want 003C", i, out_data); end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got %b want 1", in_ready); end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid) break;
        end
        checks++; if (lat !== 4) begin errors++; $display("FAIL bp_second_latency got %0d want 4", lat); end
        checks++; if (out_data !== 16'h5E68) begin errors++; $display("FAIL bp_second_data got %h want 5E68", out_data); end
        checks++; if (out_carry !== 1'b1) begin errors++; $display("FAIL bp_second_carry got %b want 1", out_carry); end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [15:0] rd;
        logic        rc, rz;
        logic [16:0] exp;
        int          lat;
        @(negedge clk);
        in_data  = 16'hFFFF;
        in_amt   = 4'd1;
        in_op    = 2'b00;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL rstmid_out_data got %h want 0000", out_data); end
        checks++; if (out_carry !== 1'b0) begin errors++; $display("FAIL rstmid_out_carry got %b want 0", out_carry); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b want 1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_release_in_ready got %b want 1", in_ready); end
        exp = model(16'h0F0F, 5, 2'b00);
        run_op(16'h0F0F, 4'd5, 2'b00, rd, rc, rz, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL rstmid_after_latency got %0d want 4", lat); end
        checks++; if (rd !== exp[15:0]) begin errors++; $display("FAIL rstmid_after_data got %h want %h", rd, exp[15:0]); end
        checks++; if (rc !== exp[16]) begin errors++; $display("FAIL rstmid_after_carry got %b want %b", rc, exp[16]); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_seq_shifter
`default_nettype wire
